fp_mul_generic: RTL and testbench

FP_MUL_GENERIC -- requirements
Module: fp_mul_generic

---
 rtl/fp_mul_pkg.sv | 10 +
 rtl/fp_mant_mul_seq.sv | 38 +++
 rtl/fp_mul_generic.sv | 161 ++++++++++++++++
 tb/tb_fp_mul_generic.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared encodings for the sequential floating-point multiplier
package fp_mul_pkg;
  typedef enum logic [1:0] {RM_RNE, RM_RTZ, RM_RUP, RM_RDN} rnd_mode_e;
  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_SPECIAL, S_MUL, S_NORM, S_ROUND, S_PACK, S_HOLD} state_e;
  typedef enum logic [2:0] {C_ZERO, C_SUB, C_NORM, C_INF, C_QNAN, C_SNAN} cls_e;
endpackage

// File: rtl/fp_mant_mul_seq.sv
// fp_mant_mul_seq: iterative shift-add unsigned multiplier, one bit per cycle.
// Ports: start loads a/b; busy high for N cycles; done marks the final step; prod valid after done.
module fp_mant_mul_seq #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] prod
);
  localparam int CW = $clog2(N+1);
  logic [CW-1:0] cnt;
  logic [N-1:0] mc;
  logic [N:0] sum;
  assign sum = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, mc} : '0);
  assign done = busy && cnt == CW'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      mc <= '0;
      prod <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= CW'(N);
      mc <= a;
      prod <= {{N{1'b0}}, b};
    end else if (busy) begin
      prod <= {sum, prod[N-1:1]};
      cnt <= cnt - CW'(1);
      busy <= !done;
    end
  end
endmodule

// File: rtl/fp_mul_generic.sv
// fp_mul_generic: sequential IEEE-754-style multiplier with valid/ready handshakes.
// Ports: clk, rst (async, active-high); in_valid/in_ready with op1, op2, rnd_mode;
// out_valid/out_ready with res and flags {NV, OF, UF, NX}.
module fp_mul_generic import fp_mul_pkg::*; #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     op1,
  input  logic [EXP_W+MAN_W:0]     op2,
  input  logic [1:0]               rnd_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     res,
  output logic [3:0]               flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int PW = 2*MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int EMAX = 2**EXP_W - 1;
  state_e st;
  rnd_mode_e rm;
  logic [W-1:0] a, b;
  logic sgn, g, rb, sb, tiny, nx;
  logic signed [EW-1:0] ex;
  logic [MAN_W:0] man;
  logic mul_busy, mul_done;
  logic [PW-1:0] prod;
  function automatic cls_e classify(input logic [W-1:0] x);
    return &x[W-2:MAN_W] ? (x[MAN_W-1:0] == '0 ? C_INF : x[MAN_W-1] ? C_QNAN : C_SNAN)
         : |x[W-2:MAN_W] ? C_NORM : |x[MAN_W-1:0] ? C_SUB : C_ZERO;
  endfunction
  function automatic logic [EXP_W-1:0] eff_exp(input logic [W-1:0] x);
    return |x[W-2:MAN_W] ? x[W-2:MAN_W] : EXP_W'(1);
  endfunction
  cls_e ca, cb;
  logic is_nan, is_snan, is_inv, is_inf, is_zero, special, psgn;
  logic [W-1:0] spec_res;
  logic [3:0] spec_flags;
  int es;
  assign ca = classify(a);
  assign cb = classify(b);
  assign psgn = a[W-1] ^ b[W-1];
  assign is_nan = ca == C_QNAN || ca == C_SNAN || cb == C_QNAN || cb == C_SNAN;
  assign is_snan = ca == C_SNAN || cb == C_SNAN;
  assign is_inv = (ca == C_ZERO && cb == C_INF) || (ca == C_INF && cb == C_ZERO);
  assign is_inf = ca == C_INF || cb == C_INF;
  assign is_zero = ca == C_ZERO || cb == C_ZERO;
  assign special = is_nan || is_inf || is_zero;
  assign es = int'(eff_exp(a)) + int'(eff_exp(b)) - BIAS;
  always_comb begin
    spec_flags = '0;
    spec_flags[FLAG_NV] = is_snan || is_inv;
    spec_res = (is_nan || is_inv) ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}}
             : is_inf ? {psgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {psgn, {(W-1){1'b0}}};
  end
  fp_mant_mul_seq #(.N(MAN_W+1)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(st == S_UNPACK && !special),
    .a({|a[W-2:MAN_W], a[MAN_W-1:0]}),
    .b({|b[W-2:MAN_W], b[MAN_W-1:0]}),
    .busy(mul_busy),
    .done(mul_done),
    .prod(prod)
  );
  // Normalise so the leading one sits at the top bit; the shift is clamped so the
  // exponent never drops below 1, and a negative shift denormalises with sticky.
  int lz, e1, sh, rsh, t;
  logic [PW-1:0] nv;
  logic [2*PW-1:0] ext;
  logic nst;
  always_comb begin
    lz = PW;
    for (int i = 0; i < PW; i++) if (prod[i]) lz = PW - 1 - i;
    e1 = int'(ex);
    sh = lz < e1 ? lz : e1;
    t = e1 + 1 - sh;
    rsh = sh < 0 ? (-sh > PW ? PW : -sh) : 0;
    ext = {prod, {PW{1'b0}}} >> rsh;
    nv = sh >= 0 ? prod << sh : ext[2*PW-1:PW];
    nst = sh < 0 && |ext[PW-1:0];
  end
  logic inexact, up, of, ovf_inf;
  logic [MAN_W+1:0] mr;
  logic [3:0] pk_flags;
  always_comb begin
    inexact = g | rb | sb;
    up = rm == RM_RNE ? g & (rb | sb | man[0]) : rm == RM_RUP ? !sgn & inexact : rm == RM_RDN ? sgn & inexact : 1'b0;
    mr = {1'b0, man} + {{(MAN_W+1){1'b0}}, up};
    of = man[MAN_W] && ex >= EMAX;
    ovf_inf = rm == RM_RNE || (rm == RM_RUP && !sgn) || (rm == RM_RDN && sgn);
    pk_flags = '0;
    pk_flags[FLAG_OF] = of;
    pk_flags[FLAG_UF] = tiny & nx;
    pk_flags[FLAG_NX] = nx | of;
  end
  assign in_ready = st == S_IDLE;
  assign out_valid = st == S_HOLD;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= S_IDLE;
      rm <= RM_RNE;
      a <= '0;
      b <= '0;
      sgn <= 1'b0;
      ex <= '0;
      man <= '0;
      {g, rb, sb, tiny, nx} <= '0;
      res <= '0;
      flags <= '0;
    end else begin
      case (st)
        S_IDLE: if (in_valid) begin
          a <= op1;
          b <= op2;
          rm <= rnd_mode_e'(rnd_mode);
          st <= S_UNPACK;
        end
        S_UNPACK: begin
          sgn <= psgn;
          ex <= EW'(es);
          if (special) begin
            res <= spec_res;
            flags <= spec_flags;
          end
          st <= special ? S_SPECIAL : S_MUL;
        end
        S_SPECIAL: st <= S_HOLD;
        S_MUL: if (mul_done || !mul_busy) st <= S_NORM;
        S_NORM: begin
          man <= nv[PW-1:MAN_W+1];
          g <= nv[MAN_W];
          rb <= nv[MAN_W-1];
          sb <= |nv[MAN_W-2:0] | nst;
          tiny <= !nv[PW-1];
          ex <= EW'(t);
          st <= S_ROUND;
        end
        S_ROUND: begin
          man <= mr[MAN_W+1] ? mr[MAN_W+1:1] : mr[MAN_W:0];
          ex <= mr[MAN_W+1] ? ex + EW'(1) : ex;
          nx <= inexact;
          st <= S_PACK;
        end
        S_PACK: begin
          res <= of ? (ovf_inf ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sgn, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}})
               : {sgn, man[MAN_W] ? ex[EXP_W-1:0] : {EXP_W{1'b0}}, man[MAN_W-1:0]};
          flags <= pk_flags;
          st <= S_HOLD;
        end
        S_HOLD: if (out_ready) st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mul_generic.sv
// tb_fp_mul_generic: directed-vector bench for fp_mul_generic (single and half-like formats)
module tb_fp_mul_generic;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid;
  logic [31:0] op1 = '0, op2 = '0, res;
  logic [1:0] rnd_mode = 2'd0;
  logic [3:0] flags;
  logic s_in_valid = 1'b0, s_out_ready = 1'b1, s_in_ready, s_out_valid;
  logic [15:0] s_op1 = '0, s_op2 = '0, s_res;
  logic [3:0] s_flags;
  int checks = 0, errors = 0;
  fp_mul_generic dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op1(op1), .op2(op2),
    .rnd_mode(rnd_mode), .out_valid(out_valid), .out_ready(out_ready), .res(res), .flags(flags)
  );
  fp_mul_generic #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .op1(s_op1), .op2(s_op2),
    .rnd_mode(2'd0), .out_valid(s_out_valid), .out_ready(s_out_ready), .res(s_res), .flags(s_flags)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic wait_out(output int lat);
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                       input logic [31:0] er, input logic [3:0] ef, input int el);
    int lat, n;
    @(negedge clk);
    op1 = a;
    op2 = b;
    rnd_mode = rm;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
    chk({tag, " res"}, res, er);
    chk({tag, " flags"}, flags, ef);
    chk({tag, " lat"}, lat, el);
    @(posedge clk);
  endtask
  initial begin
    int lat;
    logic stable, seen;
    #12;
    chk("reset res", res, 0);
    chk("reset flags", flags, 0);
    chk("reset out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", in_ready, 1);
    do_op("1.5x2", 32'h3FC00000, 32'h40000000, 2'd0, 32'h40400000, 4'h0, 29);
    do_op("ulp rne", 32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 4'h1, 29);
    do_op("ulp rup", 32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 4'h1, 29);
    do_op("ulp rtz", 32'h3F800001, 32'h3F800001, 2'd1, 32'h3F800002, 4'h1, 29);
    do_op("0xinf", 32'h00000000, 32'h7F800000, 2'd0, 32'h7FC00000, 4'h8, 3);
    do_op("snan", 32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000, 4'h8, 3);
    do_op("qnan", 32'h7FC00001, 32'h3F800000, 2'd0, 32'h7FC00000, 4'h0, 3);
    do_op("-0x5", 32'h80000000, 32'h40A00000, 2'd0, 32'h80000000, 4'h0, 3);
    do_op("infx-1", 32'h7F800000, 32'hBF800000, 2'd0, 32'hFF800000, 4'h0, 3);
    do_op("-2x3", 32'hC0000000, 32'h40400000, 2'd0, 32'hC0C00000, 4'h0, 29);
    do_op("ovf rne", 32'h7F7FFFFF, 32'h40000000, 2'd0, 32'h7F800000, 4'h5, 29);
    do_op("ovf rtz", 32'h7F7FFFFF, 32'h40000000, 2'd1, 32'h7F7FFFFF, 4'h5, 29);
    do_op("ovf rdn", 32'h7F7FFFFF, 32'h40000000, 2'd3, 32'h7F7FFFFF, 4'h5, 29);
    do_op("ovf rup neg", 32'hFF7FFFFF, 32'h40000000, 2'd2, 32'hFF7FFFFF, 4'h5, 29);
    do_op("min norm half", 32'h00800000, 32'h3F000000, 2'd0, 32'h00400000, 4'h0, 29);
    do_op("sub tie rne", 32'h00800000, 32'h3F000001, 2'd0, 32'h00400000, 4'h3, 29);
    do_op("sub tie rup", 32'h00800000, 32'h3F000001, 2'd2, 32'h00400001, 4'h3, 29);
    do_op("total uf", 32'h00000001, 32'h00000001, 2'd0, 32'h00000000, 4'h3, 29);
    @(negedge clk);
    op1 = 32'h3FC00000;
    op2 = 32'h40000000;
    rnd_mode = 2'd0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 op1 = 32'h40000000;
    op2 = 32'h40400000;
    wait_out(lat);
    stable = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res !== 32'h40400000 || flags !== 4'h0 || !out_valid) stable = 1'b0;
      if (in_ready) seen = 1'b1;
    end
    chk("stall res", res, 32'h40400000);
    chk("stall stable", stable, 1);
    chk("stall in_ready", seen, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall release in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
    chk("held op res", res, 32'h40C00000);
    @(posedge clk);
    @(negedge clk);
    op1 = 32'h3FC00000;
    op2 = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1 chk("abort res", res, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort out_valid", out_valid, 0);
    chk("abort in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (40) @(negedge clk) if (out_valid) seen = 1'b1;
    chk("abort no result", seen, 0);
    do_op("after abort", 32'h3FC00000, 32'h40000000, 2'd0, 32'h40400000, 4'h0, 29);
    @(negedge clk);
    s_op1 = 16'h3E00;
    s_op2 = 16'h4000;
    s_in_valid = 1'b1;
    @(posedge clk);
    #1 s_in_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!s_out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("half res", s_res, 16'h4200);
    chk("half flags", s_flags, 4'h0);
    chk("half lat", lat, 16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
